// File: rtl/reg_file_mp_pkg.sv
// regfile_pkg: shared state encoding and sizing helper for the multi-port register file.
package regfile_pkg;
  typedef enum logic {CLEAR, IDLE} state_t;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write/read bus of the register file; master drives addresses and data.
interface reg_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic                         Reg_Write;
  logic [ADDR_W-1:0]            Write_Register;
  logic [DATA_W-1:0]            Write_Data;
  logic [NUM_READ*ADDR_W-1:0]   Read_Register;
  logic [NUM_READ*DATA_W-1:0]   Read_Data;
  logic                         Busy;
  modport master (output Reg_Write, Write_Register, Write_Data, Read_Register, input Read_Data, Busy);
  modport slave  (input Reg_Write, Write_Register, Write_Data, Read_Register, output Read_Data, Busy);
endinterface

// File: rtl/reg_file_clear_fsm.sv
// reg_file_clear_fsm: walks every entry writing zero after reset; o_busy is high exactly while state is CLEAR.
module reg_file_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      o_busy  <= 1'b1;
    end else if (r_state == CLEAR) begin
      r_ptr <= r_ptr + ADDR_W'(1);
      if (&r_ptr) begin
        r_state <= IDLE;
        o_busy  <= 1'b0;
      end
    end
  end
  assign o_clr_we   = (r_state == CLEAR) && !rst;
  assign o_clr_addr = r_ptr;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: N-read-port register file with hardware clear; define REGFILE_FWD_EN for write-to-read bypass.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = depth(ADDR_W);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd  [NUM_READ];
  logic [DATA_W-1:0] w_rd  [NUM_READ];
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_user_we;
  reg_file_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk        (Clock),
    .rst        (Reset),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );
  assign w_user_we = bus.Reg_Write && !w_busy && !Reset &&
                     !(ZERO_REG != 0 && bus.Write_Register == '0);
  always_ff @(posedge Clock) begin
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    else if (w_user_we) r_mem[bus.Write_Register] <= bus.Write_Data;
  end
  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = bus.Read_Register[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_FWD_EN
    // w_user_we already excludes Busy and the hardwired zero entry
    assign w_rd[g] = (ZERO_REG != 0 && w_ra == '0) ? '0 :
                     (w_user_we && bus.Write_Register == w_ra) ? bus.Write_Data : r_mem[w_ra];
`else
    assign w_rd[g] = (ZERO_REG != 0 && w_ra == '0) ? '0 : r_mem[w_ra];
`endif
  end
  always_ff @(posedge Clock) begin
    for (int i = 0; i < NUM_READ; i++) r_rd[i] <= (Reset || w_busy) ? '0 : w_rd[i];
  end
  always_comb begin
    bus.Read_Data = '0;
    for (int i = 0; i < NUM_READ; i++) bus.Read_Data[i*DATA_W +: DATA_W] = r_rd[i];
  end
  assign bus.Busy = w_busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed vector table plus clear/reset sequences; ZERO_REG=1 and ZERO_REG=0 instances run side by side.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [DW-1:0] ez;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  vec_t tv [32];
  int   nv = 0;
  int   vectors = 0;
  int   errors = 0;
  int   n;
  always #5 clk = ~clk;
  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus ();
  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus_z ();
  assign bus_z.Reg_Write      = bus.Reg_Write;
  assign bus_z.Write_Register = bus.Write_Register;
  assign bus_z.Write_Data     = bus.Write_Data;
  assign bus_z.Read_Register  = bus.Read_Register;
  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1)) u_dut (
    .Clock (clk), .Reset (rst), .bus (bus));
  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(0)) u_dut_z (
    .Clock (clk), .Reset (rst), .bus (bus_z));
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic add(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                     input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] ez);
    tv[nv] = '{we, wa, wd, ra0, ra1, e0, e1, ez};
    nv++;
  endtask
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    bus.Reg_Write      = we;
    bus.Write_Register = wa;
    bus.Write_Data     = wd;
    bus.Read_Register  = {ra1, ra0};
  endtask
  task automatic wait_clear(input string nm);
    n = 0;
    while (bus.Busy && n < 100) begin
      step();
      n++;
    end
    chk(nm, DW'(n), 32);
  endtask
  initial begin
    for (int k = 0; k < 16; k++) add(1'b0, '0, '0, AW'(2*k), AW'(2*k+1), '0, '0, '0);
    add(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    add(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    add(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, FWD ? 32'h12345678 : 32'h0);
    add(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h12345678);
    add(1'b1, 5'd7, 32'h1, 5'd7, 5'd5, FWD ? 32'h1 : 32'h0, 32'hDEADBEEF, FWD ? 32'h1 : 32'h0);
    add(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, FWD ? 32'hA5A5A5A5 : 32'h1,
        FWD ? 32'hA5A5A5A5 : 32'h1, FWD ? 32'hA5A5A5A5 : 32'h1);
    add(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5);
    add(1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd6, FWD ? 32'hCAFEF00D : 32'h0, 32'h0,
        FWD ? 32'hCAFEF00D : 32'h0);
    add(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
    rst = 1'b1;
    drive(1'b0, '0, '0, 5'd3, 5'd3);
    step();
    step();
    chk("reset_busy", DW'(bus.Busy), 1);
    chk("reset_rd", bus.Read_Data[DW-1:0], '0);
    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h0000FFFF, 5'd3, 5'd3);
    step();
    chk("clear_rd_forced0", bus.Read_Data[2*DW-1:DW], '0);
    n = 1;
    while (bus.Busy && n < 100) begin
      step();
      n++;
    end
    chk("busy_len_first", DW'(n), 32);
    chk("busy_len_zdut", DW'(bus_z.Busy), 0);
    for (int i = 0; i < nv; i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].ra0, tv[i].ra1);
      step();
      chk($sformatf("vec%0d_p0", i), bus.Read_Data[DW-1:0], tv[i].e0);
      chk($sformatf("vec%0d_p1", i), bus.Read_Data[2*DW-1:DW], tv[i].e1);
      chk($sformatf("vec%0d_z0", i), bus_z.Read_Data[DW-1:0], tv[i].ez);
    end
    drive(1'b0, '0, '0, 5'd5, 5'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 5'd5, 32'h55AA55AA, 5'd5, 5'd7);
      step();
    end
    chk("midclear_busy", DW'(bus.Busy), 1);
    chk("midclear_rd", bus.Read_Data[DW-1:0], '0);
    rst = 1'b1;
    drive(1'b0, '0, '0, 5'd5, 5'd7);
    step();
    rst = 1'b0;
    wait_clear("busy_len_restart");
    step();
    chk("restart_r5", bus.Read_Data[DW-1:0], '0);
    chk("restart_r7", bus.Read_Data[2*DW-1:DW], '0);
    drive(1'b0, '0, '0, 5'd0, 5'd31);
    step();
    chk("restart_z_r0", bus_z.Read_Data[DW-1:0], '0);
    chk("restart_r31", bus.Read_Data[2*DW-1:DW], '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
